// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction-fetch front end. Streams sequential fetches from a
//   synchronous instruction memory (fixed 1-cycle read latency) and buffers
//   the returned instructions in a DEPTH-entry circular queue. The consumer
//   side is a valid/ready handshake; a single-cycle redirect flushes the
//   queue and restarts fetching at a new PC.
//
//   Optional feature macro: FETCH_BYPASS_EN
//     defined   - a response arriving while the queue is empty is presented
//                 on instr/instr_pc/instr_valid in the same cycle; if it is
//                 popped that cycle it is never written into storage.
//     undefined - outputs come only from queue storage.
//
// Ports
//   clk            in   clock, rising-edge
//   rst            in   synchronous reset, active-low
//   imem_en        out  memory read request this cycle
//   imem_addr      out  byte address of the request
//   imem_rdata     in   read data, valid one cycle after imem_en
//   instr_valid    out  queue head valid
//   instr          out  head instruction
//   instr_pc       out  address of head instruction
//   instr_ready    in   consumer accepts head
//   redirect_valid in   flush and restart fetch
//   redirect_pc    in   restart address
//   occupancy      out  entries currently held in the queue

module fetch_queue #(
    parameter int unsigned              ADDR_W   = 32,
    parameter int unsigned              INSTR_W  = 32,
    parameter int unsigned              DEPTH    = 4,
    parameter logic [ADDR_W-1:0]        RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_en,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [INSTR_W-1:0]          imem_rdata,
    output logic                        instr_valid,
    output logic [INSTR_W-1:0]          instr,
    output logic [ADDR_W-1:0]           instr_pc,
    input  logic                        instr_ready,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic [$clog2(DEPTH):0]      occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_W / 8);

    logic [ADDR_W-1:0]  fpc;
    logic               inflight;
    logic [ADDR_W-1:0]  inflightAddr;

    logic [INSTR_W-1:0] instrMem [DEPTH];
    logic [ADDR_W-1:0]  pcMem    [DEPTH];
    logic [PW-1:0]      rdPtr;
    logic [PW-1:0]      wrPtr;
    logic [CW-1:0]      count;

    logic               qValid;
    logic               bypass;
    logic               pop;
    logic               popQ;
    logic               push;
    logic [CW:0]        credit;

    always_comb begin
        qValid = (count != '0);

`ifdef FETCH_BYPASS_EN
        // Response lands on an empty queue: show it straight away.
        bypass = rst & ~qValid & inflight & ~redirect_valid;
`else
        bypass = 1'b0;
`endif

        instr_valid = qValid | bypass;
        instr       = bypass ? imem_rdata   : instrMem[rdPtr];
        instr_pc    = bypass ? inflightAddr : pcMem[rdPtr];

        pop  = instr_valid & instr_ready;
        // A bypassed pop never touched storage, so it moves no pointer.
        popQ = pop & qValid;
        push = inflight & ~redirect_valid & ~(pop & ~qValid);

        // Slots already promised: stored entries plus the response in
        // flight, less the entry leaving this cycle.
        credit  = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
        imem_en = rst & (redirect_valid | (credit < (CW+1)'(DEPTH)));

        if (!rst)
            imem_addr = RESET_PC;
        else if (redirect_valid)
            imem_addr = redirect_pc;
        else
            imem_addr = fpc;

        occupancy = count;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fpc          <= RESET_PC;
            inflight     <= 1'b0;
            inflightAddr <= '0;
            rdPtr        <= '0;
            wrPtr        <= '0;
            count        <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instrMem[i] <= '0;
                pcMem[i]    <= '0;
            end
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                inflightAddr <= imem_addr;
                fpc          <= imem_addr + STEP;
            end

            if (redirect_valid) begin
                // A pop this cycle still completes at the consumer; the
                // rest of the queue and the returning response are dropped.
                count <= '0;
                rdPtr <= '0;
                wrPtr <= '0;
            end else begin
                if (push) begin
                    instrMem[wrPtr] <= imem_rdata;
                    pcMem[wrPtr]    <= inflightAddr;
                    wrPtr           <= wrPtr + PW'(1);
                end
                if (popQ)
                    rdPtr <= rdPtr + PW'(1);
                case ({push, popQ})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  occupancy;

    int errors = 0;
    int checks = 0;
    int reqs   = 0;
    logic [31:0] expQ[$];

    fetch_queue #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (4),
        .RESET_PC (32'h100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory returning its own address as data.
    initial imem_rdata = '0;
    always @(posedge clk)
        if (imem_en) imem_rdata <= imem_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: got pc %0h expected none", instr_pc);
            end else begin
                logic [31:0] e;
                e = expQ.pop_front();
                check("deliver_pc", {32'h0, instr_pc}, {32'h0, e});
                check("deliver_data", {32'h0, instr}, {32'h0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        // Reset state
        repeat (3) cyc();
        #1;
        check("rst_imem_en", {63'h0, imem_en}, 64'h0);
        check("rst_imem_addr", {32'h0, imem_addr}, 64'h100);
        check("rst_valid", {63'h0, instr_valid}, 64'h0);
        check("rst_instr", {32'h0, instr}, 64'h0);
        check("rst_instr_pc", {32'h0, instr_pc}, 64'h0);
        check("rst_occupancy", {61'h0, occupancy}, 64'h0);

        // Streaming: requests every cycle, first valid 2 cycles later
        for (int i = 0; i < 8; i++) expQ.push_back(32'h100 + 32'(4 * i));
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k == 0) begin rst = 1'b1; instr_ready = 1'b1; end
            #1;
            check("stream_en", {63'h0, imem_en}, 64'h1);
            check("stream_addr", {32'h0, imem_addr}, 64'(32'h100 + 32'(4 * k)));
            check("stream_valid", {63'h0, instr_valid}, (k >= 2) ? 64'h1 : 64'h0);
        end
        cyc(); rst = 1'b0; instr_ready = 1'b0; #1;
        check("stream_drained", 64'(expQ.size()), 64'h0);
        cyc();

        // Backpressure: exactly DEPTH requests while stalled
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k == 0) rst = 1'b1;
            #1;
            if (imem_en) reqs++;
        end
        check("stall_reqs", 64'(reqs), 64'h4);
        check("stall_occupancy", {61'h0, occupancy}, 64'h4);
        check("stall_en", {63'h0, imem_en}, 64'h0);
        expQ.push_back(32'h100);
        cyc(); instr_ready = 1'b1; #1;                        // cycle 10
        check("resume_en", {63'h0, imem_en}, 64'h1);
        check("resume_addr", {32'h0, imem_addr}, 64'h110);

        // Redirect with 3 queued and 1 in flight
        cyc(); instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200; #1;  // 11
        check("redir_pre_occ", {61'h0, occupancy}, 64'h3);
        check("redir_en", {63'h0, imem_en}, 64'h1);
        check("redir_addr", {32'h0, imem_addr}, 64'h200);
        cyc(); redirect_valid = 1'b0; instr_ready = 1'b1; #1;  // 12
        check("redir_post_occ", {61'h0, occupancy}, 64'h0);
        check("redir_post_valid", {63'h0, instr_valid}, 64'h0);
        check("redir_next_addr", {32'h0, imem_addr}, 64'h204);
        for (int i = 0; i < 5; i++) expQ.push_back(32'h200 + 32'(4 * i));
        repeat (5) cyc();                                     // 13..17

        // Redirect in the same cycle as a pop
        expQ.push_back(32'h214);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h300; #1;  // 18
        check("redir_pop_addr", {32'h0, imem_addr}, 64'h300);
        cyc(); redirect_valid = 1'b0; #1;                     // 19
        check("redir_pop_occ", {61'h0, occupancy}, 64'h0);
        check("redir_pop_valid", {63'h0, instr_valid}, 64'h0);
        for (int i = 0; i < 3; i++) expQ.push_back(32'h300 + 32'(4 * i));
        repeat (3) cyc();                                     // 20..22

        // Back-to-back redirects
        expQ.push_back(32'h30C);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h400; #1;  // 23
        cyc(); redirect_pc = 32'h500; #1;                     // 24
        check("b2b_valid", {63'h0, instr_valid}, 64'h0);
        check("b2b_addr", {32'h0, imem_addr}, 64'h500);
        cyc(); redirect_valid = 1'b0; #1;                     // 25
        for (int i = 0; i < 3; i++) expQ.push_back(32'h500 + 32'(4 * i));
        repeat (3) cyc();                                     // 26..28

        // Address wrap
        expQ.push_back(32'h50C);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;  // 29
        cyc(); redirect_valid = 1'b0; #1;                     // 30
        check("wrap_en", {63'h0, imem_en}, 64'h1);
        check("wrap_addr", {32'h0, imem_addr}, 64'h0);
        expQ.push_back(32'hFFFF_FFFC);
        expQ.push_back(32'h0);
        expQ.push_back(32'h4);
        repeat (3) cyc();                                     // 31..33

        // One-cycle reset mid-stream
        cyc(); rst = 1'b0; #1;                                // 34
        check("midrst_drained", 64'(expQ.size()), 64'h0);
        check("midrst_en", {63'h0, imem_en}, 64'h0);
        check("midrst_addr", {32'h0, imem_addr}, 64'h100);
        cyc(); rst = 1'b1; #1;                                // 35
        check("midrst_valid", {63'h0, instr_valid}, 64'h0);
        check("midrst_occ", {61'h0, occupancy}, 64'h0);
        check("midrst_instr", {32'h0, instr}, 64'h0);
        check("midrst_pc", {32'h0, instr_pc}, 64'h0);
        check("midrst_req_en", {63'h0, imem_en}, 64'h1);
        check("midrst_req_addr", {32'h0, imem_addr}, 64'h100);
        expQ.push_back(32'h100);
        expQ.push_back(32'h104);
        cyc(); #1;                                            // 36
        check("midrst_stale_valid", {63'h0, instr_valid}, 64'h0);
        repeat (3) cyc();                                     // 37..39
        check("final_drained", 64'(expQ.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the next-generation core. It replaces the direct PC-to-BROM connection with a sequencer that streams sequential fetches and buffers returned instructions in a DEPTH-entry queue. A valid/ready handshake decouples the queue from decode/execute, and a single-cycle redirect port carries branches and jumps. The block drives a synchronous instruction memory with fixed 1-cycle read latency, so stalls downstream no longer stall the PC.

## Interface
- ADDR_W, 32, width of PC and memory address
- INSTR_W, 32, instruction width; must be a multiple of 8; PC step = INSTR_W/8
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low: state clears on a rising clk edge while rst=0
- imem_en  out  1  read request this cycle
- imem_addr  out  ADDR_W  byte address of request
- imem_rdata  in  INSTR_W  read data, valid exactly 1 cycle after imem_en
- instr_valid  out  1  queue head valid
- instr  out  INSTR_W  head instruction
- instr_pc  out  ADDR_W  address of head instruction
- instr_ready  in  1  consumer accepts head; transfer when instr_valid & instr_ready
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  ADDR_W  restart address
- occupancy  out  $clog2(DEPTH)+1  entries currently held

## Operation
- State: fetch PC register `fpc`, 1-bit `inflight`, inflight address register, queue storage, read/write pointers, count.
- Reset values: imem_en=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, occupancy=0, inflight=0, fpc=RESET_PC, all storage cleared.
- Issue rule: imem_en=1 when rst=1 and (count + inflight − pop) < DEPTH, where pop = instr_valid & instr_ready. Path from instr_ready to imem_en is combinational by design.
- On issue: imem_addr=fpc; fpc ← fpc + INSTR_W/8, wrapping modulo 2^ADDR_W; inflight ← 1; the issue address is saved.
- Response: in the cycle after an issue, imem_rdata and the saved address are pushed to the queue.
- Queue: circular buffer, pointers wrap at DEPTH. Push and pop in the same cycle are both honoured and count is unchanged. The credit rule makes overflow impossible. Pop on an empty queue cannot occur because instr_valid=0.
- Redirect (redirect_valid=1):
  - all entries are flushed and count ← 0;
  - a response arriving this cycle is discarded;
  - imem_en=1 and imem_addr=redirect_pc in the same cycle, regardless of credit;
  - fpc ← redirect_pc + INSTR_W/8.
- A pop in the redirect cycle completes as a normal transfer; the remaining entries are flushed.
- Redirect and rst=0 in the same cycle: reset wins.
- Reset mid-operation: the in-flight response returning after reset release is discarded, because inflight=0.
- Back-to-back redirects: each one discards the previous cycle's response and restarts at its own redirect_pc.

## Timing
- Steady state: one fetch per cycle when the consumer holds instr_ready=1.
- Request-to-instr_valid latency: 2 cycles (registered queue output). With FETCH_BYPASS_EN: 1 cycle, only when the queue is empty.
- Redirect-to-first-valid-instruction: 2 cycles, or 1 with bypass.
- First request: the first cycle with rst=1, at address RESET_PC.
- occupancy reflects the registered count and excludes inflight.

## Configuration
- FETCH_BYPASS_EN defined: when the queue is empty and a response arrives, instr/instr_pc/instr_valid present imem_rdata and the saved address combinationally in the same cycle. If it is popped that cycle, it is not written into the queue.
- Not defined: every response is written to the queue first; outputs come only from storage, with no combinational path from imem_rdata to the outputs.

## Test plan
- Reset release, RESET_PC=0x100, instr_ready=1, memory returns address-as-data -> requests at 0x100, 0x104, 0x108…; instr_pc equals instr each cycle; first valid at cycle 2 (cycle 1 with bypass).
- instr_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, occupancy=4, imem_en=0 until ready returns, no data lost; order preserved.
- Redirect to 0x200 while the queue holds 3 entries and one response is in flight -> occupancy=0 next cycle, imem_addr=0x200 in the redirect cycle, next delivered instr_pc=0x200, no stale PC ever delivered.
- Redirect asserted in the same cycle as a pop -> popped instruction counted as delivered; the next delivered instr_pc is redirect_pc.
- fpc=2^ADDR_W−4 with ADDR_W=32 -> following request address is 0x0.
- rst=0 asserted mid-stream for 1 cycle -> all outputs return to reset values; the next request is at RESET_PC; the response to the pre-reset request is discarded.
